// File: rtl/asym_width_fifo.sv
// Width-converting synchronous FIFO: WIDTH_A-bit words in, WIDTH_B-bit halves out, low half first.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module asym_width_fifo #(
    parameter  int unsigned WIDTH_A = 16,
    parameter  int unsigned WIDTH_B = 8,
    parameter  int unsigned DEPTH   = 256,
    localparam int unsigned ADDRESS = $clog2(DEPTH),
    localparam int unsigned CNT_W   = ADDRESS + 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [WIDTH_A-1:0] wr_data,
    output logic               full,
    input  logic               rd_en,
    output logic [WIDTH_B-1:0] rd_data,
    output logic               rd_valid,
    output logic               empty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic               overflow,
    output logic               underflow,
`endif
    output logic [CNT_W-1:0]   count
);

    logic [WIDTH_A-1:0] mem [DEPTH];
    logic [ADDRESS-1:0] wptr;
    logic [ADDRESS:0]   rptr;
    logic [CNT_W-1:0]   count_nxt;
    logic [WIDTH_A-1:0] rd_word;
    logic               wr_acc;
    logic               rd_acc;

    // Acceptance uses only pre-edge flags, so a same-cycle read never frees room for a write.
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign rd_word = mem[rptr[ADDRESS:1]];

    always_comb begin
        count_nxt = count;
        if (wr_acc) count_nxt = count_nxt + CNT_W'(2);
        if (rd_acc) count_nxt = count_nxt - CNT_W'(1);
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            count    <= count_nxt;
            full     <= (count_nxt >= CNT_W'(2 * DEPTH - 1));
            empty    <= (count_nxt == '0);
            rd_valid <= rd_acc;
            if (wr_acc) wptr <= wptr + ADDRESS'(1);
            if (rd_acc) begin
                rptr    <= rptr + (ADDRESS + 1)'(1);
                rd_data <= rptr[0] ? rd_word[WIDTH_A-1:WIDTH_B] : rd_word[WIDTH_B-1:0];
            end
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_asym_width_fifo.sv
// Directed bench for asym_width_fifo with a byte-queue reference model; honours FIFO_ERR_FLAGS_EN.
module tb_asym_width_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        full;
    logic        rd_en;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        empty;
    logic [9:0]  count;
`ifdef FIFO_ERR_FLAGS_EN
    logic        overflow;
    logic        underflow;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    int         mcount;
    logic [7:0] last_rd;
    logic       mov;
    logic       mund;

    asym_width_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .empty    (empty),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow (overflow),
        .underflow(underflow),
`endif
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock with the given requests; the model predicts every output after the edge.
    task automatic step(input logic we, input logic [15:0] wd, input logic re);
        logic       wa;
        logic       ra;
        logic [7:0] exp_b;
        exp_b   = 8'h00;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        wa = we && (mcount < 511);
        ra = re && (mcount != 0);
        if (we && mcount >= 511) mov  = 1'b1;
        if (re && mcount == 0)   mund = 1'b1;
        if (ra) exp_b = mq.pop_front();
        if (wa) begin
            mq.push_back(wd[7:0]);
            mq.push_back(wd[15:8]);
        end
        mcount = mcount + (wa ? 2 : 0) - (ra ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check("rd_valid", 32'(rd_valid), 32'(ra));
        if (ra) last_rd = exp_b;
        check("rd_data", 32'(rd_data), 32'(last_rd));
        check("count", 32'(count), 32'(mcount));
        check("full", 32'(full), 32'(mcount >= 511));
        check("empty", 32'(empty), 32'(mcount == 0));
`ifdef FIFO_ERR_FLAGS_EN
        check("overflow", 32'(overflow), 32'(mov));
        check("underflow", 32'(underflow), 32'(mund));
`endif
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        wr_data = 16'hDEAD;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mq.delete();
        mcount  = 0;
        last_rd = 8'h00;
        mov     = 1'b0;
        mund    = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
`ifdef FIFO_ERR_FLAGS_EN
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
`endif
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) step(1'b1, 16'($random), 1'b0);
    endtask

    initial begin
        logic [7:0] basic_b [4];
        logic [9:0] basic_c [4];
        basic_b = '{8'h5A, 8'hA5, 8'h34, 8'h12};
        basic_c = '{10'd3, 10'd2, 10'd1, 10'd0};
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        mcount = 0; last_rd = '0; mov = 1'b0; mund = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic order
        step(1'b1, 16'hA55A, 1'b0);
        check("basic_cnt_w1", 32'(count), 32'd2);
        step(1'b1, 16'h1234, 1'b0);
        check("basic_cnt_w2", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 1'b1);
            check("basic_data", 32'(rd_data), 32'(basic_b[i]));
            check("basic_valid", 32'(rd_valid), 32'd1);
            check("basic_cnt_r", 32'(count), 32'(basic_c[i]));
        end
        check("basic_empty", 32'(empty), 32'd1);
        step(1'b0, 16'h0, 1'b0);
        check("basic_valid_drop", 32'(rd_valid), 32'd0);

        // Fill and drain
        do_reset();
        fill();
        check("fill_full", 32'(full), 32'd1);
        check("fill_cnt", 32'(count), 32'd512);
        step(1'b1, 16'hFFFF, 1'b0);
        check("fill_cnt_over", 32'(count), 32'd512);
`ifdef FIFO_ERR_FLAGS_EN
        check("fill_overflow", 32'(overflow), 32'd1);
`endif
        for (int i = 0; i < 512; i++) step(1'b0, 16'h0, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 16'h0, 1'b1);
        check("underrun_valid", 32'(rd_valid), 32'd0);

        // Odd full
        do_reset();
        fill();
        step(1'b0, 16'h0, 1'b1);
        check("odd_cnt", 32'(count), 32'd511);
        check("odd_full", 32'(full), 32'd1);
        step(1'b1, 16'h5555, 1'b0);
        check("odd_wr_ignored", 32'(count), 32'd511);
        step(1'b0, 16'h0, 1'b1);
        check("odd_cnt2", 32'(count), 32'd510);
        check("odd_full2", 32'(full), 32'd0);
        step(1'b1, 16'h7777, 1'b0);
        check("odd_wr_ok", 32'(count), 32'd512);

        // Simultaneous
        do_reset();
        step(1'b1, 16'h0201, 1'b0);
        step(1'b1, 16'h0403, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h1110 + 16'(i) * 16'h0202), 1'b1);
        check("simul_cnt", 32'(count), 32'd14);
        for (int i = 0; i < 14; i++) step(1'b0, 16'h0, 1'b1);
        check("simul_drained", 32'(empty), 32'd1);
        step(1'b1, 16'hC0DE, 1'b1);
        check("simul_empty_valid", 32'(rd_valid), 32'd0);
        check("simul_empty_cnt", 32'(count), 32'd2);
        step(1'b0, 16'h0, 1'b1);
        check("simul_empty_lo", 32'(rd_data), 32'h00DE);
        step(1'b0, 16'h0, 1'b1);
        check("simul_empty_hi", 32'(rd_data), 32'h00C0);

        // Wrap
        do_reset();
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 200; i++) step(1'b1, 16'($random), 1'b0);
            for (int i = 0; i < 400; i++) step(1'b0, 16'h0, 1'b1);
            check("wrap_empty", 32'(empty), 32'd1);
        end

        // Reset mid-operation
        for (int i = 0; i < 5; i++) step(1'b1, 16'(16'h0100 + 16'(i)), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1);
        do_reset();
        step(1'b1, 16'hBEEF, 1'b0);
        step(1'b0, 16'h0, 1'b1);
        check("mid_lo", 32'(rd_data), 32'h00EF);
        step(1'b0, 16'h0, 1'b1);
        check("mid_hi", 32'(rd_data), 32'h00BE);
        check("mid_empty", 32'(empty), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/asym_width_fifo.md
# asym_width_fifo

- Synchronous FIFO that converts width.
- Write side accepts WIDTH_A-bit words. Read side returns them as WIDTH_B-bit halves, low half first.
- Storage is an internal WIDTH_A × DEPTH array. Read addressing works at half-word granularity, the same way as the team's asymmetric dual-port RAM.
- Sits between a 16-bit producer and an 8-bit consumer (byte serializer, UART/SPI transmit path) so that neither side has to track shared-memory addresses.

## Interface
- WIDTH_A, 16, write word width; must equal 2*WIDTH_B
- WIDTH_B, 8, read word width
- DEPTH, 256, storage depth in WIDTH_A words; power of two, ≥ 2
- ADDRESS (localparam), log2(DEPTH) = 8
- CNT_W (localparam), ADDRESS+2 = 10
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write request
- wr_data  input  WIDTH_A  write word
- full  output  1  high when fewer than 2 free WIDTH_B slots
- rd_en  input  1  read request
- rd_data  output  WIDTH_B  registered read half-word
- rd_valid  output  1  one-cycle pulse, rd_data updated
- empty  output  1  no WIDTH_B half-words stored
- count  output  CNT_W  stored WIDTH_B half-words, 0..2*DEPTH
- overflow  output  1  sticky; only with FIFO_ERR_FLAGS_EN
- underflow  output  1  sticky; only with FIFO_ERR_FLAGS_EN

## Operation
- **Write pointer:** wptr, ADDRESS bits, in WIDTH_A words.
- **Read pointer:** rptr, ADDRESS+1 bits, in WIDTH_B half-words. rptr[ADDRESS:1] selects the entry; rptr[0] selects the half (0 = wr_data[WIDTH_B-1:0], 1 = upper half).
- **Write accept:** when wr_en && !full.
  - mem[wptr] <= wr_data.
  - wptr wraps DEPTH-1 → 0.
  - count += 2.
- **Read accept:** when rd_en && !empty.
  - rd_data <= selected half.
  - rd_valid <= 1.
  - rptr wraps 2*DEPTH-1 → 0.
  - count -= 1.
- **Simultaneous write and read accept:** count += 1 net.
- **Flags:** full = (count ≥ 2*DEPTH-1); empty = (count == 0).
  - Both are registered, derived from the next-state count.
  - Both are evaluated against the pre-edge state. A same-cycle read cannot make room for a write, and a same-cycle write cannot satisfy a read.
- **Write while full:** ignored; memory, wptr and count unchanged.
- **Read while empty:** ignored; rd_valid stays 0 and rd_data holds its value.
- **Odd count (2*DEPTH-1):** full stays asserted until the remaining half is read out.
- **Reset:** wptr = 0, rptr = 0, count = 0, empty = 1, full = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data. rst has priority over wr_en and rd_en in the same cycle.

## Timing
- **Write to readable:** a word written at edge N is visible to a read at edge N+1, because empty deasserts after edge N.
- **Read latency:** 1 cycle. rd_en accepted at edge N gives rd_data and rd_valid valid after edge N, held until edge N+1.
- **rd_valid:** deasserts at the next edge with no accepted read.
- **Back-to-back reads:** rd_en held high gives one half-word per cycle.
- **Back-to-back writes:** wr_en held high gives one word per cycle until full.
- **Flag update:** full, empty and count change on the same edge as the accepted operation.

## Configuration
- **Macro:** FIFO_ERR_FLAGS_EN.
- **Defined:**
  - overflow and underflow ports exist.
  - overflow sets on wr_en && full; underflow sets on rd_en && empty.
  - Both flags are sticky and cleared only by rst.
- **Undefined:** the ports and their logic are absent. Rejected requests are dropped silently.

## Test plan
- **Basic order:**
  - Stimulus: after reset, write 16'hA55A then 16'h1234; then read 4 times.
  - Required: rd_data = 8'h5A, 8'hA5, 8'h34, 8'h12, each with rd_valid = 1.
  - Required: count goes 0 → 2 → 4 → 3 → 2 → 1 → 0; empty = 1 at the end.
- **Fill:**
  - Stimulus: write 256 words of $random.
  - Required: full = 1 and count = 512 after word 256. A 257th write of 16'hFFFF leaves count at 512; overflow = 1 if enabled.
  - Stimulus: read 512 times.
  - Required: each half matches the model in order.
- **Odd full:**
  - Stimulus: fill, then read 1.
  - Required: count = 511, full stays 1, and a write is ignored.
  - Stimulus: read 1 more.
  - Required: count = 510, full = 0, and the next write is accepted.
- **Simultaneous:**
  - Stimulus: with count = 4, wr_en and rd_en together for 10 cycles.
  - Required: count ends at 14; the output stream is unbroken and in order.
  - Stimulus: with empty = 1, wr_en and rd_en together.
  - Required: the write is accepted, rd_valid = 0, count = 2.
- **Wrap:**
  - Stimulus: repeat for 3 passes: write 200 words, then read 400 halves.
  - Required: data intact across the wptr and rptr wrap boundaries.
- **Reset mid-op:**
  - Stimulus: write 5 words and read 3, then assert rst for 1 cycle.
  - Required: count = 0, empty = 1, rd_valid = 0, rd_data = 0, error flags = 0.
  - Stimulus: write 16'hBEEF.
  - Required: the next two reads give 8'hEF, 8'hBE.
